bin2bcd_seq_ctrl: RTL
=====================

# bin2bcd_seq_ctrl

Sequential binary-to-BCD converter controller using the shift-and-add-3 algorithm. It replaces the fully unrolled combinational correction array with one row of digit-correction cells that is reused once per input bit. A small FSM with valid/ready handshakes on both sides sequences that row. The block sits between a binary producer (counter, ADC sample) and a BCD display or formatting stage, and trades latency for area.

## Interface
- `WIDTH`, default 8: binary input width; legal range 4–16.
- `DIGITS`, default 3: BCD output digits; must satisfy 10^DIGITS > 2^WIDTH−1, which is checked at elaboration.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: `in_bin` is valid.
- `in_ready`  out  1: block can accept a value.
- `in_bin`  in  WIDTH: unsigned binary value.
- `out_valid`  out  1: `out_bcd` holds a completed result.
- `out_ready`  in  1: consumer takes the result.
- `out_bcd`  out  4*DIGITS: packed BCD, digit 0 (units) in [3:0].
- `busy`  out  1: a conversion is in progress (SHIFT state).

## Operation
- Internal state:
  - `bin_q` (WIDTH): shift register for the binary value.
  - `bcd_q` (4*DIGITS): BCD accumulator.
  - `cnt_q`: counter, $clog2(WIDTH+1) bits.
  - FSM state.
- FSM states and transitions:
  - IDLE → SHIFT on accept (`in_valid && in_ready`).
  - SHIFT → DONE when `cnt_q` reaches 1 and that shift completes.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → SHIFT on `out_ready && in_valid`, which is a back-to-back accept.
- Accept:
  - `bin_q <= in_bin`, `bcd_q <= 0`, `cnt_q <= WIDTH`.
- Each SHIFT cycle:
  - Every digit d ≥ 5 becomes d+3 (4-bit, no carry out of the digit).
  - The corrected `{bcd, bin}` concatenation then shifts left by 1. `bin_q` MSB enters the BCD LSB and a 0 enters the `bin_q` LSB.
  - `cnt_q` decrements.
- Correction is applied before the shift in the same cycle. No correction is applied after the final shift.
- `in_ready`:
  - 1 in IDLE.
  - Equal to `out_ready` in DONE.
  - 0 in SHIFT.
- `out_valid`: 1 only in DONE.
- `out_bcd`:
  - Equals `bcd_q`.
  - Only meaningful while `out_valid` is 1.
  - Holds stable in DONE until the handshake.
- `in_bin` is sampled only on the accept edge. Later changes have no effect.
- Every digit of a completed result is ≤ 9.
- Reset mid-operation: all state returns to reset values immediately. The in-flight conversion is discarded and no `out_valid` is produced for it.
- `in_valid` while in SHIFT is ignored, because `in_ready` is 0 there. The producer must hold the value.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `busy` = 0.
  - `out_bcd` = 0.
  - `bin_q` = 0 and `cnt_q` = 0.
- Latency: `out_valid` rises WIDTH clock edges after the accept edge (8 for the default).
- `busy` is high for exactly WIDTH cycles per conversion.
- Throughput:
  - Back-to-back, with `out_ready` tied high: one result per WIDTH+1 cycles.
  - Each DONE cycle with `out_ready` = 1 also accepts the next input.
- Backpressure: DONE persists indefinitely while `out_ready` is 0. No input is accepted during that time and no data is lost.
- All outputs are registered or decoded from registered state only. There is no combinational path from inputs to outputs except `in_ready` ← `out_ready` in DONE.

## Structure
- Package `bcd_pkg`:
  - State enum `bcd_state_t` {IDLE, SHIFT, DONE}.
  - Constant `BCD_DIGIT_W` = 4.
  - Function `min_digits(width)` for the elaboration check.
- Sub-module `bcd_digit_adj`: combinational 4-bit cell, output = in ≥ 5 ? in+3 : in. It is instantiated DIGITS times by a generate loop.
- Top module: FSM, counter, and the shift registers.

## Test plan
- Reset, then accept `in_bin` = 0 → `out_valid` 8 cycles later, `out_bcd` = 12'h000.
- `in_bin` = 255 → `out_bcd` = 12'h255. `busy` high exactly 8 cycles.
- `out_ready` tied high, in_valid held with 200 then 7 → results 12'h200 and 12'h007. Second accept occurs in the first result's DONE cycle, 9 cycles apart.
- `out_ready` low for 20 cycles after `in_bin` = 99 → `out_bcd` holds 12'h099 and `in_ready` stays 0 throughout. Release pulls the result and returns to IDLE.
- `rst_n` asserted at SHIFT cycle 4 of `in_bin` = 173 → next edge shows IDLE and all outputs at reset values, with no `out_valid`. A new accept of 173 then yields 12'h173.
- Exhaustive sweep of 0..255 with random `out_ready` → every result equals the reference decimal conversion and every digit is ≤ 9.

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the sequential binary-to-BCD converter
package bcd_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
  localparam int BCD_DIGIT_W = 4;
  function automatic int min_digits(input int width);
    int v, d;
    v = (1 << width) - 1;
    d = 1;
    for (int i = 0; i < 6; i++) if (v >= 10) begin
      v = v / 10;
      d++;
    end
    return d;
  endfunction
endpackage

// File: rtl/bin2bcd_seq_ctrl_if.sv
// bin2bcd_seq_ctrl_if: producer/consumer handshake bundle of the BCD converter
interface bin2bcd_seq_ctrl_if import bcd_pkg::*; #(parameter int WIDTH = 8, parameter int DIGITS = 3);
  logic in_valid, in_ready, out_valid, out_ready, busy;
  logic [WIDTH-1:0] in_bin;
  logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
  modport master(output in_valid, in_bin, out_ready, input in_ready, out_valid, out_bcd, busy);
  modport slave(input in_valid, in_bin, out_ready, output in_ready, out_valid, out_bcd, busy);
endinterface

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: add-3 correction of one BCD digit before it is doubled
module bcd_digit_adj import bcd_pkg::*; (
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq_ctrl.sv
// bin2bcd_seq_ctrl: shift-and-add-3 converter reusing one correction row per input bit
module bin2bcd_seq_ctrl import bcd_pkg::*; #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  bin2bcd_seq_ctrl_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = BCD_DIGIT_W * DIGITS;
  if (WIDTH < 4 || WIDTH > 16 || DIGITS < min_digits(WIDTH)) begin : g_chk
    $error("bin2bcd_seq_ctrl: illegal WIDTH/DIGITS combination");
  end
  bcd_state_t state_q;
  logic [WIDTH-1:0] bin_q;
  logic [BW-1:0] bcd_q, adj;
  logic [CW-1:0] cnt_q;
  logic accept;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .d(bcd_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q(adj[i*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end
  // out_ready reaches in_ready in DONE so a result and the next input swap in one cycle
  assign bus.in_ready  = state_q == IDLE || (state_q == DONE && bus.out_ready);
  assign bus.out_valid = state_q == DONE;
  assign bus.busy      = state_q == SHIFT;
  assign bus.out_bcd   = bcd_q;
  assign accept        = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= SHIFT;
      bin_q   <= bus.in_bin;
      bcd_q   <= '0;
      cnt_q   <= CW'(WIDTH);
    end else if (state_q == SHIFT) begin
      bin_q   <= {bin_q[WIDTH-2:0], 1'b0};
      bcd_q   <= {adj[BW-2:0], bin_q[WIDTH-1]};
      cnt_q   <= cnt_q - 1'b1;
      state_q <= cnt_q == CW'(1) ? DONE : SHIFT;
    end else if (state_q == DONE && bus.out_ready) begin
      state_q <= IDLE;
    end
endmodule
